// File: rtl/multi_debouncer_pkg.sv
// Shared types and sizing helpers for the multi-channel debouncer.
package multi_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CONF_HI = 2'b01,
    PRESSED = 2'b10,
    CONF_LO = 2'b11
  } dbState_e;

  // Width of the per-channel tick counter: it must hold the larger of the
  // stability and long-press targets without wrapping.
  function automatic int cntWidth(input int stableTicks, input int longTicks);
    int maxTicks;
    maxTicks = (stableTicks > longTicks) ? stableTicks : longTicks;
    return (maxTicks < 1) ? 1 : $clog2(maxTicks + 1);
  endfunction

  // Width of the shared prescaler, which counts 0..tickDiv-1.
  function automatic int prescWidth(input int tickDiv);
    return (tickDiv < 2) ? 1 : $clog2(tickDiv);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: synchroniser, four-state qualification FSM,
// tick counter and registered level/pulse outputs.
module debounce_channel #(
  parameter int STABLE_TICKS = 3,
  parameter int LONG_TICKS   = 100,
  parameter int SYNC_STAGES  = 2,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic button_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic longPress_o
);
  import multi_debouncer_pkg::*;

  localparam int CW = cntWidth(STABLE_TICKS, LONG_TICKS);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_TICKS);
  localparam logic [CW-1:0] LONG_C   = CW'(LONG_TICKS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sIn;
  dbState_e               state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cntInc;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   longPress_q, longPress_d;

  assign sIn    = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
  assign cntInc = cnt_q + CW'(1);

  // Shift the raw pad value through the synchroniser chain; reset to the idle pad level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_i};
    end
  end

  // Next-state logic: any disagreement with the confirming direction aborts
  // immediately, even when it coincides with a tick.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    longPress_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sIn) begin
          state_d = CONF_HI;
          cnt_d   = '0;
        end
      end
      CONF_HI: begin
        if (!sIn) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (cntInc == STABLE_C) begin
            state_d = PRESSED;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cntInc;
          end
        end
      end
      PRESSED: begin
        if (!sIn) begin
          state_d = CONF_LO;
          cnt_d   = '0;
        end else if (tick_i && (cnt_q != LONG_C)) begin
          cnt_d = cntInc;
          if (cntInc == LONG_C) begin
            longPress_d = 1'b1;
          end
        end
      end
      CONF_LO: begin
        if (sIn) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (cntInc == STABLE_C) begin
            state_d   = IDLE;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cntInc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // Register FSM state, counter and all outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      longPress_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      longPress_q <= longPress_d;
    end
  end

  assign level_o     = level_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign longPress_o = longPress_q;

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel push-button debouncer: shared sample-tick prescaler plus
// one independent debounce_channel per input.
module multi_debouncer #(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = 500000,
  parameter int STABLE_TICKS = 3,
  parameter int LONG_TICKS   = 100,
  parameter int SYNC_STAGES  = 2,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] long_press_o,
  output logic                tick_o
);
  import multi_debouncer_pkg::*;

  localparam int PW = prescWidth(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;

  // Prescaler wraps at TICK_DIV-1; tick is registered so it is high exactly
  // while the count sits at its last value.
  always_comb begin
    presc_d = (presc_q == TICK_LAST) ? '0 : presc_q + PW'(1);
    tick_d  = (presc_d == TICK_LAST);
  end

  // Register the prescaler and its strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_o = tick_q;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : gChannel
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS),
      .SYNC_STAGES (SYNC_STAGES),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) uChannel (
      .clk        (clk),
      .reset      (reset),
      .tick_i     (tick_q),
      .button_i   (button_i[ch]),
      .level_o    (level_o[ch]),
      .press_o    (press_o[ch]),
      .release_o  (release_o[ch]),
      .longPress_o(long_press_o[ch])
    );
  end

endmodule
